maj_vote_seq: RTL

Parametrised, sequential successor to the combinational 5-bit majority function. It accepts a WIDTH-bit vote word over a valid/ready handshake and scans it LSB-first, LANES bits per cycle, with a small FSM. It then returns the population count and a threshold decision over a second valid/ready handshake. It sits between a vote-collection stage and downstream control logic wherever a wide or variable-threshold vote is too costly to evaluate in one combinational cone.

---
 rtl/maj_vote_pkg.sv | 33 +++
 rtl/maj_lane_popcount.sv | 40 ++++
 rtl/maj_vote_seq.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/maj_vote_pkg.sv
// maj_vote_pkg: shared state type and elaboration helpers for maj_vote_seq.
// Early scan termination is enabled by defining MAJ_VOTE_EARLY_EXIT_EN.
package maj_vote_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

  function automatic int grp_n(input int w, input int l);
    return (l < 1) ? 1 : (w + l - 1) / l;
  endfunction

  function automatic int idx_w(input int s);
    return (s > 1) ? $clog2(s) : 1;
  endfunction

  function automatic bit params_ok(
    input int w,
    input int l,
    input int t
  );
    return (w >= 1) && (w <= 64) &&
           (l >= 1) && (l <= w) &&
           (t >= 0) && (t <= w + 1);
  endfunction

endpackage

// File: rtl/maj_lane_popcount.sv
// maj_lane_popcount: ones count of the vote group selected by idx.
// The word is zero-extended to whole groups so the tail group is masked.
module maj_lane_popcount
  import maj_vote_pkg::*;
#(
  parameter int WIDTH = 5,
  parameter int LANES = 1,
  localparam int S  = grp_n(WIDTH, LANES),
  localparam int IW = idx_w(S),
  localparam int PW = $clog2(LANES + 1)
) (
  input  logic [WIDTH-1:0] word,
  input  logic [IW-1:0]    idx,
  output logic [PW-1:0]    pop
);

  localparam int PADW = S * LANES;

  logic [PADW-1:0]  padded;
  logic [LANES-1:0] grp;

  assign padded = PADW'(word);

  always_comb begin
    grp = '0;
    for (int g = 0; g < S; g++) begin
      if (idx == IW'(g)) begin
        grp = padded[g*LANES +: LANES];
      end
    end
  end

  always_comb begin
    pop = '0;
    for (int b = 0; b < LANES; b++) begin
      pop = pop + PW'(grp[b]);
    end
  end

endmodule

// File: rtl/maj_vote_seq.sv
// maj_vote_seq: LSB-first sequential vote counter with threshold decision.
// Define MAJ_VOTE_EARLY_EXIT_EN to stop the scan once the outcome is fixed.
module maj_vote_seq
  import maj_vote_pkg::*;
#(
  parameter int WIDTH  = 5,
  parameter int LANES  = 1,
  parameter int THRESH = WIDTH / 2 + 1,
  localparam int CW = cnt_w(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out,
  output logic [CW-1:0]    count,
  output logic             early
);

  localparam int S  = grp_n(WIDTH, LANES);
  localparam int IW = idx_w(S);
  localparam int PW = $clog2(LANES + 1);
  // One extra bit so THRESH = WIDTH+1 compares without truncation.
  localparam int AW = CW + 1;

  localparam logic [IW-1:0] LAST = IW'(S - 1);
  localparam logic [AW-1:0] TH   = AW'(THRESH);

  if (!params_ok(WIDTH, LANES, THRESH)) begin : g_bad_params
    $error("maj_vote_seq: illegal WIDTH/LANES/THRESH");
  end

  state_t           state_q, state_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [CW-1:0]    cnt_q, cnt_d, cnt_nx;
  logic [PW-1:0]    pop;
  logic             out_q, out_d;

`ifdef MAJ_VOTE_EARLY_EXIT_EN
  localparam logic [AW-1:0] LN = AW'(LANES);

  logic [AW-1:0] left_q, left_d, left_nx;
  logic          early_q, early_d;
  logic          hit, miss;
`endif

  maj_lane_popcount #(
    .WIDTH (WIDTH),
    .LANES (LANES)
  ) u_pop (
    .word (word_q),
    .idx  (idx_q),
    .pop  (pop)
  );

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    cnt_nx  = cnt_q + CW'(pop);
`ifdef MAJ_VOTE_EARLY_EXIT_EN
    left_d  = left_q;
    early_d = early_q;
    // Bits still unscanned once the current group is added.
    left_nx = (left_q > LN) ? left_q - LN : '0;
    hit     = {1'b0, cnt_nx} >= TH;
    miss    = ({1'b0, cnt_nx} + left_nx) < TH;
`endif
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = SCAN;
          word_d  = in;
          idx_d   = '0;
          cnt_d   = '0;
          out_d   = 1'b0;
`ifdef MAJ_VOTE_EARLY_EXIT_EN
          left_d  = AW'(WIDTH);
          early_d = 1'b0;
`endif
        end
      end
      SCAN: begin
        cnt_d = cnt_nx;
        idx_d = idx_q + IW'(1);
`ifdef MAJ_VOTE_EARLY_EXIT_EN
        left_d = left_nx;
        if (hit || miss) begin
          state_d = DONE;
          out_d   = hit;
          early_d = (idx_q != LAST);
        end
`else
        if (idx_q == LAST) begin
          state_d = DONE;
          out_d   = {1'b0, cnt_nx} >= TH;
        end
`endif
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      word_q  <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      out_q   <= 1'b0;
`ifdef MAJ_VOTE_EARLY_EXIT_EN
      left_q  <= '0;
      early_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
`ifdef MAJ_VOTE_EARLY_EXIT_EN
      left_q  <= left_d;
      early_q <= early_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out       = out_q;
  assign count     = cnt_q;

`ifdef MAJ_VOTE_EARLY_EXIT_EN
  assign early = early_q;
`else
  assign early = 1'b0;
`endif

endmodule
